// File: rtl/pattern_and_or_pkg.sv
// Shared definitions for the pattern_and_or unit and its driver:
// op encoding, driver FSM states and the default datapath width.
package pattern_and_or_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_AND  = 2'b01,
    OP_OR   = 2'b10,
    OP_BOTH = 2'b11
  } opType;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    RESP   = 2'b10
  } stateType;

endpackage

// File: rtl/pattern_and_or_driver_if.sv
// Request/response channel between the command fabric (master) and the
// pattern_and_or driver (slave).
interface pattern_and_or_driver_if
  import pattern_and_or_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             reqValid;
  logic             reqReady;
  logic [1:0]       reqOp;
  logic [WIDTH-1:0] reqA;
  logic [WIDTH-1:0] reqB;
  logic             rspValid;
  logic             rspReady;
  logic [WIDTH-1:0] rspData;
  logic             rspErr;

  modport master (
    output reqValid, reqOp, reqA, reqB, rspReady,
    input  reqReady, rspValid, rspData, rspErr
  );

  modport slave (
    input  reqValid, reqOp, reqA, reqB, rspReady,
    output reqReady, rspValid, rspData, rspErr
  );

endinterface

// File: rtl/pattern_and_or_checker.sv
// Combinational expectation check of one pattern_and_or result against the
// operands and op that produced it.
module pattern_and_or_checker
  import pattern_and_or_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  opType            op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] unitOut,
  input  logic             unitIsAnd,
  output logic             mismatch
);

  // 4-state compares so an X/Z on any checked bit flags a mismatch.
  // isAnd is only meaningful after AND; OR leaves it stale, NOP/BOTH leave it X.
  always_comb begin
    mismatch = 1'b0;
    case (op)
      OP_AND:  mismatch = (unitOut !== (a & b)) || (unitIsAnd !== 1'b1);
      OP_OR:   mismatch = (unitOut !== (a | b));
      default: mismatch = (unitOut !== '0);
    endcase
  end

endmodule

// File: rtl/pattern_and_or_driver.sv
// Initiator-side sequencer for one pattern_and_or unit: accepts a request,
// drives the unit for a settle cycle, samples and checks the result, responds.
module pattern_and_or_driver
  import pattern_and_or_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  pattern_and_or_driver_if.slave bus,
  output logic [WIDTH-1:0]     aIn,
  output logic [WIDTH-1:0]     bIn,
  output logic                 doAnd,
  output logic                 doOr,
  input  logic [WIDTH-1:0]     unitOut,
  input  logic                 unitIsAnd,
  output logic [ERR_CNT_W-1:0] errCount
);

  stateType         state;
  stateType         nextState;
  opType            opReg;
  logic             alive;
  logic             accept;
  logic             finishSettle;
  logic             mismatch;
  logic [WIDTH-1:0] rspDataReg;
  logic             rspErrReg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  // Keeps reqReady low while in reset even though the state is already IDLE.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) alive <= 1'b0;
    else       alive <= 1'b1;
  end

  always_comb begin
    nextState    = state;
    accept       = 1'b0;
    finishSettle = 1'b0;
    bus.reqReady = 1'b0;
    bus.rspValid = 1'b0;
    case (state)
      IDLE: begin
        bus.reqReady = alive;
        if (alive && bus.reqValid) begin
          accept    = 1'b1;
          nextState = SETTLE;
        end
      end
      SETTLE: begin
        finishSettle = 1'b1;
        nextState    = RESP;
      end
      RESP: begin
        bus.rspValid = 1'b1;
        if (bus.rspReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Unit lines are live only during SETTLE; idle (all zero) otherwise.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      aIn   <= '0;
      bIn   <= '0;
      doAnd <= 1'b0;
      doOr  <= 1'b0;
      opReg <= OP_NOP;
    end else if (accept) begin
      aIn   <= bus.reqA;
      bIn   <= bus.reqB;
      doAnd <= bus.reqOp[0];
      doOr  <= bus.reqOp[1];
      opReg <= opType'(bus.reqOp);
    end else if (finishSettle) begin
      aIn   <= '0;
      bIn   <= '0;
      doAnd <= 1'b0;
      doOr  <= 1'b0;
    end
  end

  pattern_and_or_checker #(
    .WIDTH(WIDTH)
  ) resultChecker (
    .op       (opReg),
    .a        (aIn),
    .b        (bIn),
    .unitOut  (unitOut),
    .unitIsAnd(unitIsAnd),
    .mismatch (mismatch)
  );

  // Response registers only load at the end of SETTLE, so they stay stable in RESP.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rspDataReg <= '0;
      rspErrReg  <= 1'b0;
      errCount   <= '0;
    end else if (finishSettle) begin
      rspDataReg <= unitOut;
      rspErrReg  <= mismatch;
      if (mismatch && (errCount != '1)) errCount <= errCount + ERR_CNT_W'(1);
    end
  end

  assign bus.rspData = rspDataReg;
  assign bus.rspErr  = rspErrReg;

endmodule

// File: tb/tb_pattern_and_or_driver.sv
// Randomised self-checking bench for pattern_and_or_driver; the bench also
// plays the pattern_and_or unit, with injectable faults.
module tb_pattern_and_or_driver;

  localparam int W    = 4;
  localparam int EW   = 8;
  localparam int EMAX = (1 << EW) - 1;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           cnt;
  } expT;

  logic          clk;
  logic          rstN;
  logic [W-1:0]  aIn, bIn, unitOut;
  logic          doAnd, doOr, unitIsAnd;
  logic [EW-1:0] errCount;
  logic [W-1:0]  faultMask;
  logic          forceIsAndZero;
  logic          staleIsAnd;

  int  vectors = 0;
  int  miscompares = 0;
  int  modelErrCnt = 0;
  expT expQ[$];

  pattern_and_or_driver_if #(.WIDTH(W)) busIf ();

  pattern_and_or_driver #(
    .WIDTH    (W),
    .ERR_CNT_W(EW)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .bus      (busIf),
    .aIn      (aIn),
    .bIn      (bIn),
    .doAnd    (doAnd),
    .doOr     (doOr),
    .unitOut  (unitOut),
    .unitIsAnd(unitIsAnd),
    .errCount (errCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the unit; faultMask corrupts its result bits.
  assign unitOut   = ((doAnd && !doOr) ? (aIn & bIn) :
                      (doOr && !doAnd) ? (aIn | bIn) : '0) ^ faultMask;
  assign unitIsAnd = doAnd ? !forceIsAndZero : staleIsAnd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstN && busIf.rspValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected rspValid", busIf.rspValid, 1'b0);
      end else begin
        checkOutput("rspData", busIf.rspData, expQ[0].data);
        checkOutput("rspErr", busIf.rspErr, expQ[0].err);
        checkOutput("errCount", errCount, expQ[0].cnt);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] mask, input logic forceZero, input int rspDelay,
                               input logic holdNext, output logic [W-1:0] gotData, output logic gotErr);
    logic [W-1:0] uOut;
    logic         uIsAnd;
    logic         err;
    expT          e;
    @(negedge clk);
    faultMask      = mask;
    forceIsAndZero = forceZero;
    staleIsAnd     = 1'($urandom_range(0, 1));
    busIf.reqOp    = op;
    busIf.reqA     = a;
    busIf.reqB     = b;
    busIf.reqValid = 1'b1;
    checkOutput("reqReady in idle", busIf.reqReady, 1'b1);
    @(posedge clk); #1;
    busIf.reqValid = 1'b0;
    checkOutput("doAnd on accept", doAnd, op[0]);
    checkOutput("doOr on accept", doOr, op[1]);
    checkOutput("aIn on accept", aIn, a);
    checkOutput("bIn on accept", bIn, b);
    checkOutput("reqReady in settle", busIf.reqReady, 1'b0);
    checkOutput("rspValid in settle", busIf.rspValid, 1'b0);
    // What the unit shows the sampler, then the rules the driver must apply to it.
    case (op)
      2'b01:   begin uOut = (a & b) ^ mask; uIsAnd = !forceZero; err = (uOut != (a & b)) || !uIsAnd; end
      2'b10:   begin uOut = (a | b) ^ mask; err = (uOut != (a | b)); end
      default: begin uOut = mask;           err = (uOut != '0); end
    endcase
    if (err && modelErrCnt < EMAX) modelErrCnt++;
    e.data = uOut;
    e.err  = err;
    e.cnt  = modelErrCnt;
    expQ.push_back(e);
    @(posedge clk); #1;
    checkOutput("rspValid after settle", busIf.rspValid, 1'b1);
    checkOutput("unit cmd lines idle", {doAnd, doOr}, 2'b00);
    checkOutput("unit operand lines idle", {aIn, bIn}, '0);
    gotData = busIf.rspData;
    gotErr  = busIf.rspErr;
    for (int i = 0; i < rspDelay; i++) begin
      if (holdNext) begin
        busIf.reqValid = 1'b1;
        busIf.reqOp    = 2'($urandom);
        busIf.reqA     = W'($urandom);
        busIf.reqB     = W'($urandom);
      end
      @(posedge clk); #1;
      checkOutput("reqReady under backpressure", busIf.reqReady, 1'b0);
    end
    busIf.rspReady = 1'b1;
    @(posedge clk); #1;
    busIf.rspReady = 1'b0;
    void'(expQ.pop_front());
    checkOutput("rspValid after handshake", busIf.rspValid, 1'b0);
  endtask

  task automatic resetMidOperation();
    @(negedge clk);
    busIf.reqOp    = 2'b01;
    busIf.reqA     = 4'hF;
    busIf.reqB     = 4'hF;
    busIf.reqValid = 1'b1;
    @(posedge clk); #2;
    busIf.reqValid = 1'b0;
    rstN = 1'b0;
    #1;
    expQ.delete();
    modelErrCnt = 0;
    checkOutput("reset doAnd/doOr", {doAnd, doOr}, 2'b00);
    checkOutput("reset aIn/bIn", {aIn, bIn}, '0);
    checkOutput("reset rspValid", busIf.rspValid, 1'b0);
    checkOutput("reset rspData", busIf.rspData, '0);
    checkOutput("reset rspErr", busIf.rspErr, 1'b0);
    checkOutput("reset errCount", errCount, modelErrCnt);
    checkOutput("reset reqReady", busIf.reqReady, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no rspValid after abort", busIf.rspValid, 1'b0);
      checkOutput("reqReady after abort", busIf.reqReady, 1'b1);
    end
  endtask

  initial begin
    logic [W-1:0] d;
    logic         r;
    rstN           = 1'b0;
    busIf.reqValid = 1'b0;
    busIf.reqOp    = 2'b00;
    busIf.reqA     = '0;
    busIf.reqB     = '0;
    busIf.rspReady = 1'b0;
    faultMask      = '0;
    forceIsAndZero = 1'b0;
    staleIsAnd     = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("initial reqReady", busIf.reqReady, 1'b0);
    checkOutput("initial rspValid", busIf.rspValid, 1'b0);
    checkOutput("initial errCount", errCount, 0);
    checkOutput("initial unit lines", {doAnd, doOr, aIn, bIn}, '0);
    rstN = 1'b1;

    applyStimulus(2'b01, 4'b1100, 4'b1010, 4'b0000, 1'b0, 0, 1'b0, d, r);
    checkOutput("AND literal data", d, 4'b1000);
    checkOutput("AND literal err", r, 1'b0);
    applyStimulus(2'b10, 4'b1100, 4'b0011, 4'b0000, 1'b0, 0, 1'b0, d, r);
    checkOutput("OR literal data", d, 4'b1111);
    checkOutput("OR literal err", r, 1'b0);
    applyStimulus(2'b01, 4'b1100, 4'b1010, 4'b0000, 1'b1, 0, 1'b0, d, r);
    checkOutput("AND isAnd fault err", r, 1'b1);
    applyStimulus(2'b00, 4'b0110, 4'b0101, 4'b0001, 1'b0, 0, 1'b0, d, r);
    checkOutput("NOP fault data", d, 4'b0001);
    checkOutput("NOP fault err", r, 1'b1);
    checkOutput("errCount after two faults", errCount, 2);

    applyStimulus(2'b01, 4'b1111, 4'b0101, 4'b0000, 1'b0, 5, 1'b1, d, r);
    applyStimulus(2'b11, 4'b1111, 4'b1111, 4'b0000, 1'b0, 0, 1'b0, d, r);
    checkOutput("BOTH literal data", d, 4'b0000);

    for (int i = 0; i < 150; i++) begin
      applyStimulus(2'($urandom), W'($urandom), W'($urandom),
                    ($urandom_range(0, 3) == 0) ? W'($urandom) : '0,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0), d, r);
    end

    for (int i = 0; i < 260; i++) begin
      applyStimulus(2'b00, W'($urandom), W'($urandom), W'($urandom_range(1, 15)), 1'b0, 0, 1'b0, d, r);
    end
    checkOutput("errCount saturated", errCount, 8'hFF);

    resetMidOperation();
    applyStimulus(2'b10, 4'b1000, 4'b0001, 4'b0000, 1'b0, 0, 1'b0, d, r);
    checkOutput("OR after reset data", d, 4'b1001);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_and_or_driver.md
# pattern_and_or_driver

Initiator-side sequencer for the `pattern_and_or` logic unit. It accepts operation requests over a valid/ready channel and drives the unit's `aIn`/`bIn`/`doAnd`/`doOr` lines. It samples the unit's `out`/`isAnd` after a settle cycle and checks them against locally computed expected values. Each request produces exactly one response carrying the result and an error flag. It sits between the test/command fabric and one `pattern_and_or` instance.

## Interface
- `WIDTH`, 4: operand/result width; must match the unit.
- `ERR_CNT_W`, 8: width of the saturating error counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rstN`  in  1  reset, asynchronous assert, active-low.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  block can accept a request.
- `reqOp`  in  2  00 NOP, 01 AND, 10 OR, 11 BOTH (illegal combination, forwarded as-is).
- `reqA`, `reqB`  in  WIDTH  operands.
- `aIn`, `bIn`  out  WIDTH  registered operand lines to the unit.
- `doAnd`, `doOr`  out  1  registered command lines to the unit.
- `unitOut`  in  WIDTH  unit `out`.
- `unitIsAnd`  in  1  unit `isAnd`.
- `rspValid`  out  1  response present.
- `rspReady`  in  1  consumer accepts response.
- `rspData`  out  WIDTH  sampled `unitOut`.
- `rspErr`  out  1  sampled result mismatched expectation.
- `errCount`  out  ERR_CNT_W  number of responses with `rspErr`=1, saturating.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: `reqReady`=1, and the unit lines are idle (`doAnd`=`doOr`=0, `aIn`=`bIn`=0). When `reqValid`&&`reqReady`:
  - register `reqA`→`aIn` and `reqB`→`bIn`;
  - set `doAnd`=`reqOp[0]` and `doOr`=`reqOp[1]`;
  - store the op;
  - go to SETTLE.
- SETTLE: `reqReady`=0 and the unit lines are held. At the end of the cycle:
  - sample `unitOut`→`rspData`;
  - compute `rspErr`;
  - return the unit lines to idle;
  - go to RESP.
- RESP: `rspValid`=1 and response regs are held stable. On `rspReady`: clear `rspValid` and go to IDLE.
- Expected values:
  - AND: `unitOut`==A&B and `unitIsAnd`==1.
  - OR: `unitOut`==A|B; `unitIsAnd` not checked (unit leaves it stale).
  - NOP/BOTH: `unitOut`==0; `unitIsAnd` not checked (unit drives X).
  - Any X/Z on a checked bit counts as mismatch (4-state compare with `!==`).
- `errCount` increments by 1 on the SETTLE→RESP transition when the mismatch is set. At all-ones it holds.
- Only one request is in flight; no pipelining. A new request is accepted only in IDLE.

## Timing
- Reset (async, `rstN`=0): state IDLE; `reqReady`=0 while in reset, 1 from the first cycle after release; `rspValid`=0; `rspData`=0; `rspErr`=0; `errCount`=0; `aIn`=`bIn`=0; `doAnd`=`doOr`=0.
- Latency: request accepted at edge N; unit lines valid after N; sample at edge N+1; `rspValid`=1 after N+1. Minimum request-to-request period is 3 cycles (accept, settle, response handshake).
- `rspReady` held high means the response lives exactly one cycle; IDLE is then re-entered and `reqReady`=1 the following cycle.
- `rspValid` must not drop, and `rspData`/`rspErr` must not change, until accepted.
- `reqValid` in SETTLE/RESP is ignored and never lost silently: the requester holds it, since `reqReady`=0.
- Reset mid-operation aborts the transaction. No response is produced, the unit lines go idle immediately, and `errCount` clears.

## Structure
- Shared package `pattern_and_or_pkg`: op encoding constants (OP_NOP/AND/OR/BOTH), FSM state encoding, default WIDTH.
- One combinational sub-module, `pattern_and_or_checker`: inputs op, A, B, `unitOut`, `unitIsAnd`; outputs the mismatch bit. It is reusable by the bench as a reference model.
- The top contains the FSM, operand/response registers and the error counter.

## Test plan
- AND: A=4'b1100, B=4'b1010, unit model correct → `doAnd`=1 for 1 cycle, `rspData`=4'b1000, `rspErr`=0, `rspValid` 2 cycles after accept.
- OR: A=4'b1100, B=4'b0011 → `rspData`=4'b1111, `rspErr`=0. The unit's stale `isAnd`=1 is ignored.
- Fault injection: AND with the model forced to `unitIsAnd`=0, then NOP with `unitOut`=4'b0001 → both `rspErr`=1, `errCount`=2.
- Backpressure: `rspReady`=0 for 5 cycles with a second `reqValid` pending → response stable, `reqReady`=0 throughout. The second request is accepted the cycle after the handshake.
- Saturation: ERR_CNT_W=2 with 5 faulty ops → `errCount` stops at 3.
- Reset: assert `rstN` in SETTLE → all outputs at reset values asynchronously, no `rspValid` after release.
